// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver.
// Holds the scan state encoding, segment bit positions and the
// nibble-to-segment lookup table (bit order {g,f,e,d,c,b,a}, active high).
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Segment bit positions on the 8-bit bus {dp,g,f,e,d,c,b,a}
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Entry n is the pattern for hex digit n (element 15 listed first)
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/bin_to_7seg_decoder.sv
// Combinational hex nibble to 7-segment decoder.
// Ports: nibble_i - 4-bit value; seg_o_c - {g,f,e,d,c,b,a}, active high.
module bin_to_7seg_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o_c
);

  assign seg_o_c = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_digit_scanner.sv
// Time-multiplexed multi-digit 7-segment scanner with blanking gap,
// leading-zero suppression and frame-boundary shadow latching.
// Ports: clk/rstb (async active-low), ena (global hold), enable (run),
//   data_in/dp_in/lz_blank (display content), prescale (dwell-1),
//   seg {dp,g..a}, dig_en one-hot, digit_idx, frame_done pulse.
module seg7_digit_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned PRESC_W   = 16,
  parameter int unsigned BLANK_CYC = 2,
  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  input  logic [PRESC_W-1:0]    prescale,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  localparam int unsigned BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int unsigned CNT_W = (PRESC_W > BLK_W) ? PRESC_W : BLK_W;
  localparam bit          HAS_BLANK = (BLANK_CYC != 0);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [4*DIGITS-1:0]   sh_data_q, sh_data_d;
  logic [DIGITS-1:0]     sh_dp_q, sh_dp_d;
  logic                  sh_lz_q, sh_lz_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_en_q, dig_en_d;
  logic                  frame_done_q, frame_done_d;
  logic                  advance;

  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic                  lz_sel;
  logic                  tail_zero;
  logic [DIGITS-1:0]     lz_mask;
  logic [DIGITS-1:0]     onehot;
  logic [6:0]            dec_seg;

  // Scan sequencing: dwell counter, digit index, shadow reloads
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    presc_d      = presc_q;
    sh_data_d    = sh_data_q;
    sh_dp_d      = sh_dp_q;
    sh_lz_d      = sh_lz_q;
    frame_done_d = 1'b0;
    advance      = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          sh_data_d = data_in;
          sh_dp_d   = dp_in;
          sh_lz_d   = lz_blank;
          presc_d   = prescale;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = SHOW;
        end
        SHOW: begin
          if (cnt_q == CNT_W'(presc_q)) begin
            cnt_d = '0;
            if (HAS_BLANK) state_d = BLANK;
            else           advance = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
            cnt_d   = '0;
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      // Digit step folded into the SHOW/BLANK exit edge
      if (advance) begin
        state_d = SHOW;
        presc_d = prescale;
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          idx_d        = '0;
          frame_done_d = 1'b1;
          sh_data_d    = data_in;
          sh_dp_d      = dp_in;
          sh_lz_d      = lz_blank;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Digit mux and leading-zero mask, evaluated on the state being entered
  always_comb begin
    nib_sel   = 4'h0;
    dp_sel    = 1'b0;
    lz_sel    = 1'b0;
    onehot    = '0;
    lz_mask   = '0;
    tail_zero = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      tail_zero  = tail_zero & (sh_data_d[4*k +: 4] == 4'h0);
      lz_mask[k] = tail_zero & (k != 0);
    end
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib_sel   = sh_data_d[4*k +: 4];
        dp_sel    = sh_dp_d[k];
        lz_sel    = sh_lz_d & lz_mask[k];
        onehot[k] = 1'b1;
      end
    end
  end

  bin_to_7seg_decoder u_dec (
    .nibble_i (nib_sel),
    .seg_o_c  (dec_seg)
  );

  // Output image for the next state; dark outside SHOW
  always_comb begin
    seg_d    = '0;
    dig_en_d = '0;
    if (state_d == SHOW) begin
      seg_d[SEG_DP]      = dp_sel;
      seg_d[SEG_G:SEG_A] = lz_sel ? 7'h00 : dec_seg;
      dig_en_d           = onehot;
    end
  end

  // State and output registers; ena low freezes everything
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      presc_q      <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_lz_q      <= 1'b0;
      seg_q        <= '0;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      presc_q      <= presc_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_lz_q      <= sh_lz_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_digit_scanner.sv
// Directed self-checking bench for seg7_digit_scanner (DIGITS=4, BLANK_CYC=2).
module tb_seg7_digit_scanner;

  logic        clk;
  logic        rstb;
  logic        ena;
  logic        enable;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [15:0] prescale;
  logic [7:0]  seg;
  logic [3:0]  dig_en;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_digit_scanner #(
    .DIGITS    (4),
    .PRESC_W   (16),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .ena        (ena),
    .enable     (enable),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .prescale   (prescale),
    .seg        (seg),
    .dig_en     (dig_en),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Advance one cycle and compare all outputs
  task automatic cyc(input logic [3:0] e_dig, input logic [7:0] e_seg,
                     input logic [1:0] e_idx, input logic e_fd);
    @(negedge clk);
    chk("dig_en", 32'(dig_en), 32'(e_dig));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("digit_idx", 32'(digit_idx), 32'(e_idx));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic show_digit(input int d, input logic [7:0] s, input int presc, input logic fd);
    for (int c = 0; c <= presc; c++)
      cyc(4'(32'd1 << d), s, 2'(d), fd && (c == 0));
  endtask

  task automatic blank_digit(input int d);
    for (int b = 0; b < 2; b++) cyc(4'h0, 8'h00, 2'(d), 1'b0);
  endtask

  // exp packs digit3..digit0 segment bytes
  task automatic run_frame(input logic [31:0] exp, input int presc, input logic fd_first);
    for (int d = 0; d < 4; d++) begin
      show_digit(d, exp[8*d +: 8], presc, fd_first && (d == 0));
      blank_digit(d);
    end
  endtask

  initial begin
    rstb     = 1'b0;
    ena      = 1'b1;
    enable   = 1'b0;
    data_in  = 16'h0000;
    dp_in    = 4'h0;
    lz_blank = 1'b0;
    prescale = 16'd3;

    // Reset and idle with enable low
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_dig", 32'(dig_en), 32'h0);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    rstb = 1'b1;
    repeat (5) cyc(4'h0, 8'h00, 2'd0, 1'b0);

    // Basic scan: F, A, 2, 1
    data_in  = 16'h12AF;
    prescale = 16'd3;
    enable   = 1'b1;
    run_frame(32'h065B7771, 3, 1'b0);
    run_frame(32'h065B7771, 3, 1'b1);
    enable = 1'b0;
    cyc(4'h0, 8'h00, 2'd0, 1'b0);

    // Leading-zero suppression; lz_blank change mid-frame waits for the boundary
    data_in  = 16'h0050;
    dp_in    = 4'b1000;
    lz_blank = 1'b1;
    prescale = 16'd0;
    enable   = 1'b1;
    @(posedge clk);
    #1 lz_blank = 1'b0;
    run_frame(32'h80006D3F, 0, 1'b0);
    run_frame(32'hBF3F6D3F, 0, 1'b1);
    enable = 1'b0;
    cyc(4'h0, 8'h00, 2'd0, 1'b0);

    // Tear-free update
    data_in  = 16'h1111;
    dp_in    = 4'h0;
    prescale = 16'd3;
    enable   = 1'b1;
    @(posedge clk);
    #1 data_in = 16'h2222;
    run_frame(32'h06060606, 3, 1'b0);
    run_frame(32'h5B5B5B5B, 3, 1'b1);

    // Stop during the blanking gap of digit 2, then restart
    show_digit(0, 8'h5B, 3, 1'b1);
    blank_digit(0);
    show_digit(1, 8'h5B, 3, 1'b0);
    blank_digit(1);
    show_digit(2, 8'h5B, 3, 1'b0);
    cyc(4'h0, 8'h00, 2'd2, 1'b0);
    enable = 1'b0;
    cyc(4'h0, 8'h00, 2'd0, 1'b0);
    cyc(4'h0, 8'h00, 2'd0, 1'b0);
    data_in = 16'h4321;
    enable  = 1'b1;
    run_frame(32'h664F5B06, 3, 1'b0);

    // ena freeze at the frame boundary holds frame_done and stretches the dwell
    cyc(4'b0001, 8'h06, 2'd0, 1'b1);
    ena = 1'b0;
    repeat (10) cyc(4'b0001, 8'h06, 2'd0, 1'b1);
    ena = 1'b1;
    repeat (3) cyc(4'b0001, 8'h06, 2'd0, 1'b0);
    blank_digit(0);
    show_digit(1, 8'h5B, 3, 1'b0);

    // Asynchronous reset between clock edges
    #2 rstb = 1'b0;
    #1;
    chk("arst_seg", 32'(seg), 32'h0);
    chk("arst_dig", 32'(dig_en), 32'h0);
    chk("arst_idx", 32'(digit_idx), 32'h0);
    chk("arst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rstb = 1'b1;
    cyc(4'b0001, 8'h06, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
